// File: rtl/alu_op_sched.sv
// alu_op_sched: single-issue scheduler feeding a boolean unit and a shift unit.
// Latency: grant in cycle T, start pulse T+1, result-mux select T+L+1, rsp_valid T+L+2
//          (L = 1 for boolean, SHIFT_LAT for shift).
// Backpressure: one op in flight; req_ready stays low until the response handshake completes.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester handshake (bit i = requester i)
//   req_class              per-requester unit select (0 boolean, 1 shift)
//   req_tag                per-requester tag, requester 0 in the low TAG_W bits
//   bool_start/shift_start one-cycle unit launch pulses
//   en                     one-hot result-mux select (bit0 boolean, bit1 shift)
//   rsp_valid/rsp_ready    response handshake; rsp_tag/rsp_port identify the op
//   busy                   high whenever the FSM is not IDLE
//
// Configuration macro: ALU_OP_SCHED_RR_EN selects round-robin arbitration;
// when undefined, requester 0 has fixed priority.
module alu_op_sched #(
  parameter int SHIFT_LAT = 2,
  parameter int TAG_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_class,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic               bool_start,
  output logic               shift_start,
  output logic [1:0]         en,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_port,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, SEL, RSP} state_t;

  localparam logic [3:0] SHIFT_L = 4'(SHIFT_LAT);

  state_t           state;
  logic [3:0]       cnt;
  logic             cls_q;
  logic [TAG_W-1:0] tag_q;
  logic             port_q;

  logic             gnt_any;
  logic             gnt_idx;
  logic             xfer;
  logic             cls_sel;
  logic [TAG_W-1:0] tag_sel;

`ifdef ALU_OP_SCHED_RR_EN
  // Pointer names the requester that wins a tie; it moves only on a transfer.
  logic ptr;

  always_comb begin
    gnt_any = |req_valid;
    if (req_valid == 2'b11) gnt_idx = ptr;
    else                    gnt_idx = req_valid[1] & ~req_valid[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr <= 1'b0;
    else if (xfer) ptr <= ~gnt_idx;
  end
`else
  always_comb begin
    gnt_any = |req_valid;
    gnt_idx = req_valid[1] & ~req_valid[0];
  end
`endif

  // req_ready is combinational so the grant lands in the same cycle as the
  // request; it is forced low while reset is held so every output reads 0.
  always_comb begin
    xfer      = rst_n && (state == IDLE) && gnt_any;
    req_ready = 2'b00;
    if (xfer) req_ready = gnt_idx ? 2'b10 : 2'b01;
    cls_sel   = req_class[gnt_idx];
    tag_sel   = gnt_idx ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      cls_q       <= 1'b0;
      tag_q       <= '0;
      port_q      <= 1'b0;
      bool_start  <= 1'b0;
      shift_start <= 1'b0;
      en          <= 2'b00;
      rsp_valid   <= 1'b0;
    end else begin
      bool_start  <= 1'b0;
      shift_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer) begin
            cls_q       <= cls_sel;
            tag_q       <= tag_sel;
            port_q      <= gnt_idx;
            cnt         <= cls_sel ? SHIFT_L : 4'd1;
            bool_start  <= ~cls_sel;
            shift_start <= cls_sel;
            state       <= EXEC;
          end
        end
        EXEC: begin
          // Counter holds the EXEC cycles remaining including this one.
          if (cnt <= 4'd1) begin
            cnt   <= 4'd0;
            en    <= cls_q ? 2'b10 : 2'b01;
            state <= SEL;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        SEL: begin
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            en        <= 2'b00;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_tag  = tag_q;
  assign rsp_port = port_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_alu_op_sched.sv
// tb_alu_op_sched: directed scenario bench for alu_op_sched (SHIFT_LAT=2, TAG_W=4).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled before the next edge.
// Works with or without ALU_OP_SCHED_RR_EN defined.
module tb_alu_op_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] req_class;
  logic [7:0] req_tag;
  logic       bool_start;
  logic       shift_start;
  logic [1:0] en;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_tag;
  logic       rsp_port;
  logic       busy;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  alu_op_sched #(.SHIFT_LAT(2), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_class(req_class), .req_tag(req_tag),
    .bool_start(bool_start), .shift_start(shift_start),
    .en(en), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_tag(rsp_tag), .rsp_port(rsp_port), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] outs;
    rst_n = 1'b0; req_valid = 2'b11; req_class = 2'b00; req_tag = 8'h00; rsp_ready = 1'b0;
    tick(); tick();
    outs = {req_ready, bool_start, shift_start, en, rsp_valid, rsp_tag, rsp_port, busy};
    chk_cnt++;
    if (outs !== 13'd0) $display("FAIL reset_outputs got=%b want=0", outs);
    else pass_cnt++;
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_bool();
    req_valid = 2'b01; req_class = 2'b00; req_tag = 8'h05;
    #1;
    chk_cnt++;
    if (req_ready !== 2'b01) $display("FAIL bool_grant got=%b want=01", req_ready); else pass_cnt++;
    tick(); req_valid = 2'b00; #1;
    chk_cnt++;
    if ({bool_start, shift_start, en} !== 4'b1000)
      $display("FAIL bool_start got=%b want=1000", {bool_start, shift_start, en}); else pass_cnt++;
    tick();
    chk_cnt++;
    if ({en, rsp_valid, bool_start} !== 4'b0100)
      $display("FAIL bool_sel got=%b want=0100", {en, rsp_valid, bool_start}); else pass_cnt++;
    tick();
    chk_cnt++;
    if ({rsp_valid, rsp_tag, rsp_port, en} !== 8'b1_0101_0_01)
      $display("FAIL bool_rsp got=%b want=10101001", {rsp_valid, rsp_tag, rsp_port, en}); else pass_cnt++;
    rsp_ready = 1'b1;
    tick(); rsp_ready = 1'b0; #1;
    chk_cnt++;
    if ({rsp_valid, en, busy} !== 4'b0000)
      $display("FAIL bool_done got=%b want=0000", {rsp_valid, en, busy}); else pass_cnt++;
  endtask

  task automatic test_shift_stall();
    req_valid = 2'b10; req_class = 2'b10; req_tag = 8'h90;
    #1;
    chk_cnt++;
    if (req_ready !== 2'b10) $display("FAIL shift_grant got=%b want=10", req_ready); else pass_cnt++;
    tick(); req_valid = 2'b01; req_tag = 8'h93; #1;   // requester 0 waits behind the shift op
    chk_cnt++;
    if ({bool_start, shift_start, req_ready} !== 4'b0100)
      $display("FAIL shift_start got=%b want=0100", {bool_start, shift_start, req_ready}); else pass_cnt++;
    tick();
    chk_cnt++;
    if ({en, shift_start} !== 3'b000) $display("FAIL shift_exec2 got=%b want=000", {en, shift_start}); else pass_cnt++;
    tick();
    chk_cnt++;
    if ({en, rsp_valid} !== 3'b100) $display("FAIL shift_sel got=%b want=100", {en, rsp_valid}); else pass_cnt++;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk_cnt++;
      if ({en, rsp_valid, rsp_tag, rsp_port, busy, req_ready} !== 11'b10_1_1001_1_1_00)
        $display("FAIL shift_stall%0d got=%b want=10110011100", i,
                 {en, rsp_valid, rsp_tag, rsp_port, busy, req_ready});
      else pass_cnt++;
      tick();
    end
    rsp_ready = 1'b1; #1;
    chk_cnt++;
    if ({rsp_valid, req_ready} !== 3'b100)
      $display("FAIL shift_hs_cycle got=%b want=100", {rsp_valid, req_ready}); else pass_cnt++;
    tick(); rsp_ready = 1'b0; #1;
    chk_cnt++;
    if ({en, req_ready} !== 4'b0001)
      $display("FAIL pending_kept got=%b want=0001", {en, req_ready}); else pass_cnt++;
    tick(); req_valid = 2'b00;
    tick(); tick(); #1;
    chk_cnt++;
    if ({rsp_valid, rsp_tag, rsp_port} !== 6'b1_0011_0)
      $display("FAIL pending_rsp got=%b want=100110", {rsp_valid, rsp_tag, rsp_port}); else pass_cnt++;
    rsp_ready = 1'b1;
    tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_withdraw();
    logic bad = 1'b0;
    req_valid = 2'b01; req_class = 2'b00; req_tag = 8'h01;
    tick(); req_valid = 2'b10;
    tick();
    tick(); req_valid = 2'b00; rsp_ready = 1'b1;
    tick(); rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (busy || req_ready != 2'b00 || bool_start || shift_start) bad = 1'b1;
      tick();
    end
    chk_cnt++;
    if (bad !== 1'b0) $display("FAIL withdraw got=issued want=idle"); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    logic [11:0] outs;
    req_valid = 2'b01; req_class = 2'b01; req_tag = 8'h07;
    tick(); req_valid = 2'b00; #1;
    chk_cnt++;
    if (shift_start !== 1'b1) $display("FAIL mid_shift_start got=%b want=1", shift_start); else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    outs = {bool_start, shift_start, en, rsp_valid, rsp_tag, rsp_port, busy, req_ready[0]};
    chk_cnt++;
    if (outs !== 12'd0) $display("FAIL mid_reset_outputs got=%b want=0", outs); else pass_cnt++;
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid || busy) seen = 1'b1;
    end
    chk_cnt++;
    if (seen !== 1'b0) $display("FAIL mid_reset_ghost got=rsp want=none"); else pass_cnt++;
    req_valid = 2'b11; req_class = 2'b00; req_tag = 8'h21;
    #1;
    chk_cnt++;
    if (req_ready !== 2'b01) $display("FAIL ptr_restart got=%b want=01", req_ready); else pass_cnt++;
    tick(); req_valid = 2'b00;
    tick(); tick(); rsp_ready = 1'b1;
    tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_arb();
    logic exp_g [4];
    logic got_g [4];
    int   n = 0;
    logic overlap = 1'b0;
`ifdef ALU_OP_SCHED_RR_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    req_valid = 2'b11; req_class = 2'b00; req_tag = 8'h21; rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (req_ready != 2'b00) begin
        got_g[n] = req_ready[1];
        if (rsp_valid || en != 2'b00 || req_ready == 2'b11) overlap = 1'b1;
        n++;
      end
      tick();
    end
    chk_cnt++;
    if (n !== 4) $display("FAIL arb_count got=%0d want=4", n); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (i < n && got_g[i] === exp_g[i]) pass_cnt++;
      else $display("FAIL arb_grant%0d got=%b want=%b", i, (i < n) ? got_g[i] : 1'bx, exp_g[i]);
    end
    chk_cnt++;
    if (overlap !== 1'b0) $display("FAIL arb_hs_overlap got=1 want=0"); else pass_cnt++;
    req_valid = 2'b00;
    for (int c = 0; c < 10 && busy; c++) tick();
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL arb_drain got=busy want=idle"); else pass_cnt++;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_bool();
    test_shift_stall();
    test_withdraw();
    test_reset_mid();
    test_reset();
    test_arb();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_op_sched.md
ALU_OP_SCHED -- requirements
Module: alu_op_sched

Interface
REQ-001 Parameter SHIFT_LAT, default 2, shift-unit latency in cycles, legal range 1..15.
REQ-002 Parameter TAG_W, default 4, request tag width in bits.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  2  per-requester op valid; bit i is requester i.
REQ-006 req_ready  output  2  per-requester accept; at most one bit high per cycle.
REQ-007 req_class  input  2  per-requester unit select: 0 = boolean unit, 1 = shift unit.
REQ-008 req_tag  input  2*TAG_W  per-requester tag; bits [TAG_W-1:0] belong to requester 0.
REQ-009 bool_start  output  1  one-cycle launch pulse to the boolean unit.
REQ-010 shift_start  output  1  one-cycle launch pulse to the shift unit.
REQ-011 en  output  2  one-hot result-mux select: bit0 = boolean, bit1 = shift; drives the registered output mux.
REQ-012 rsp_valid  output  1  registered mux output holds a completed result.
REQ-013 rsp_ready  input  1  consumer accepts the result.
REQ-014 rsp_tag  output  TAG_W  tag of the completed op.
REQ-015 rsp_port  output  1  index of the requester that issued the completed op.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, EXEC, SEL, RSP; only one op in flight.
REQ-018 req_ready is zero outside IDLE; in IDLE the arbiter raises req_ready for exactly one valid requester; transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-019 On a transfer in cycle T, capture class, tag and port, then go to EXEC.
REQ-020 In cycle T+1, the start pulse for the captured class is high for exactly one cycle; the other start stays low.
REQ-021 Entering EXEC loads a down-counter with L: 1 for boolean, SHIFT_LAT for shift. EXEC lasts exactly L cycles (T+1..T+L), then the FSM goes to SEL.
REQ-022 In SEL (cycle T+L+1), en is the one-hot code for the captured class; en is 2'b00 in IDLE and EXEC and never 2'b11.
REQ-023 In RSP, en holds its SEL value so the mux keeps recapturing a stable result; rsp_valid is high and rsp_tag/rsp_port are stable until rsp_ready.
REQ-024 rsp_valid first rises in cycle T+L+2: boolean T+3, shift (SHIFT_LAT=2) T+4.
REQ-025 rsp_valid and rsp_ready both high -> IDLE next cycle with en = 0. A new transfer cannot occur in the same cycle as the response handshake.
REQ-026 Requests arriving while busy are not accepted; they stay pending with req_ready = 0 and are not lost.
REQ-027 A valid request withdrawn before its handshake is never issued.

Reset
REQ-028 While rst_n is low, FSM = IDLE, counter = 0, the round-robin pointer selects requester 0, and all outputs are 0. This applies immediately, mid-operation included, and any in-flight start pulse is dropped.
REQ-029 First possible transfer occurs in the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro ALU_OP_SCHED_RR_EN is the only configuration macro.
  - Defined: round-robin arbitration. With both requesters valid, the requester not granted last wins; the pointer updates only on a transfer.
  - Undefined: fixed priority. Requester 0 always wins when valid, and there is no pointer state.

Verification
REQ-031 Reset, then req_valid=01, class0=0, tag0=5: req_ready=01 at T, bool_start at T+1, en=01 at T+2, rsp_valid with rsp_tag=5 and rsp_port=0 at T+3.
REQ-032 Shift op with SHIFT_LAT=2, tag=9: shift_start at T+1, en=10 from T+3, rsp_valid at T+4. rsp_ready held low 3 cycles: en, rsp_tag and rsp_valid stay stable, busy=1, req_ready=00.
REQ-033 Both requesters continuously valid, rsp_ready=1:
  - With ALU_OP_SCHED_RR_EN, grants alternate 0,1,0,1.
  - Without it, all four grants go to requester 0.
REQ-034 rst_n pulsed low during EXEC of a shift op: all outputs 0 immediately, no rsp_valid afterward, the next request is accepted in IDLE, and the pointer restarts at requester 0.
REQ-035 Response handshake in cycle X with req_valid=11: req_ready=00 in X, grant issued in X+1, en=00 in X+1.
